// File: rtl/fifo_wr_arbiter_if.sv
// ============================================================================
//  Module   : fifo_wr_arbiter_if
//  Brief    : Requester streams and FIFO write port shared by fifo_wr_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          wrt_full;
    logic                          wrt_ena;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic [ID_W-1:0]               grant_id;
    logic                          busy;

    // Producers and the FIFO full flag drive this side
    modport master (
        output req_valid, req_data, wrt_full,
        input  req_ready, wrt_ena, wr_data, grant_id, busy
    );

    // The arbiter itself
    modport slave (
        input  req_valid, req_data, wrt_full,
        output req_ready, wrt_ena, wr_data, grant_id, busy
    );
endinterface

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Brief    : Round-robin, burst-limited arbiter for the async FIFO write port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  wire logic            wrt_clk,
    input  wire logic            wrt_rst,
    fifo_wr_arbiter_if.slave     bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [ID_W-1:0]  C_LAST_RST  = ID_W'(NUM_REQ - 1);

    logic [0:0]       r_state;
    logic [ID_W-1:0]  r_grant;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [ID_W-1:0]  r_last;

    logic [0:0]       w_state_nxt;
    logic [ID_W-1:0]  w_grant_nxt;
    logic [CNT_W-1:0] w_beat_nxt;
    logic [ID_W-1:0]  w_last_nxt;

    logic             w_gnt_valid;
    logic             w_xfer;
    logic             w_rearb;
    logic             w_hit;
    logic [ID_W-1:0]  w_base;
    logic [ID_W-1:0]  w_pick;

    // First valid index after base, wrapping; base itself is checked last
    function automatic logic [ID_W-1:0] f_pick(
        input logic [NUM_REQ-1:0] v,
        input logic [ID_W-1:0]    base
    );
        logic            found;
        logic [ID_W-1:0] res;
        int              idx;
        found = 1'b0;
        res   = base;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(base) + k) % NUM_REQ;
            if (!found && v[idx]) begin
                found = 1'b1;
                res   = ID_W'(idx);
            end
        end
        return res;
    endfunction

    assign w_gnt_valid = bus.req_valid[r_grant];
    assign w_xfer      = (r_state == S_GRANT) && w_gnt_valid && !bus.wrt_full;
    assign w_rearb     = (r_state == S_GRANT) &&
                         ((w_xfer && (r_beat_cnt == C_LAST_BEAT)) || !w_gnt_valid);
    assign w_hit       = |bus.req_valid;
    assign w_base      = (r_state == S_GRANT) ? r_grant : r_last;
    assign w_pick      = f_pick(bus.req_valid, w_base);

    always_ff @(posedge wrt_clk or posedge wrt_rst) begin
        if (wrt_rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_beat_cnt <= '0;
            r_last     <= C_LAST_RST;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_last     <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_beat_nxt  = r_beat_cnt;
        w_last_nxt  = r_last;
        case (r_state)
            S_IDLE: begin
                w_beat_nxt = '0;
                if (w_hit) begin
                    w_state_nxt = S_GRANT;
                    w_grant_nxt = w_pick;
                end
            end
            S_GRANT: begin
                if (w_rearb) begin
                    // The search wraps back to the current grantee, so any hit keeps us busy
                    w_last_nxt  = r_grant;
                    w_beat_nxt  = '0;
                    w_grant_nxt = w_hit ? w_pick : r_grant;
                    w_state_nxt = w_hit ? S_GRANT : S_IDLE;
                end else if (w_xfer) begin
                    w_beat_nxt = r_beat_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_beat_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.wrt_ena   = 1'b0;
        bus.busy      = 1'b0;
        bus.wr_data   = bus.req_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
        bus.grant_id  = r_grant;
        if (r_state == S_GRANT) begin
            bus.busy               = 1'b1;
            bus.req_ready[r_grant] = !bus.wrt_full;
            bus.wrt_ena            = w_gnt_valid && !bus.wrt_full;
        end
    end

    a_no_write_when_full : assert property (
        @(posedge wrt_clk) disable iff (wrt_rst) !(bus.wrt_ena && bus.wrt_full));

    a_beat_in_range : assert property (
        @(posedge wrt_clk) disable iff (wrt_rst) r_beat_cnt <= C_LAST_BEAT);

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Brief    : Directed and randomised self-checking bench for fifo_wr_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
        .wrt_clk (clk),
        .wrt_rst (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    logic [5:0] st;
    assign st = {bus.busy, bus.wrt_ena, bus.req_ready};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.wrt_full  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.req_valid = 4'b1111;
        bus.wrt_full  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({st, bus.grant_id} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold: got %b expected %b", {st, bus.grant_id}, 8'h00);
        end
        do_reset();
        @(negedge clk);
        n_checks++;
        if (st !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b expected %b", st, 6'b0);
        end
    endtask

    task automatic test_single();
        logic [15:0] exp;
        do_reset();
        bus.req_valid = 4'b0001;
        bus.req_data[7:0] = 8'h10;
        @(negedge clk);
        n_checks++;
        if (st !== 6'b0) begin
            n_fail++;
            $display("FAIL single_latency: got %b expected %b", st, 6'b0);
        end
        step();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp = {6'b11_0001, 2'd0, 8'h10 + 8'(k)};
            n_checks++;
            if ({st, bus.grant_id, bus.wr_data} !== exp) begin
                n_fail++;
                $display("FAIL single_beat%0d: got %h expected %h", k, {st, bus.grant_id, bus.wr_data}, exp);
            end
            step();
            if (k < 5) bus.req_data[7:0] = 8'h11 + 8'(k);
            else       bus.req_valid = 4'b0000;
        end
        @(negedge clk);
        n_checks++;
        if (st !== 6'b10_0001) begin
            n_fail++;
            $display("FAIL single_drop: got %b expected %b", st, 6'b10_0001);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (st !== 6'b0) begin
            n_fail++;
            $display("FAIL single_idle: got %b expected %b", st, 6'b0);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  cnt [4];
        logic [15:0] exp;
        int          g;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 4'h0;
            bus.req_data[i*8 +: 8] = {4'(i), 4'h0};
        end
        bus.req_valid = 4'b1111;
        @(negedge clk);
        n_checks++;
        if (st !== 6'b0) begin
            n_fail++;
            $display("FAIL rr_latency: got %b expected %b", st, 6'b0);
        end
        step();
        for (int k = 0; k < 20; k++) begin
            g = (k / 4) % 4;
            @(negedge clk);
            exp = {2'b11, 4'(1 << g), 2'(g), 4'(g), cnt[g]};
            n_checks++;
            if ({st, bus.grant_id, bus.wr_data} !== exp) begin
                n_fail++;
                $display("FAIL rr_beat%0d: got %h expected %h", k, {st, bus.grant_id, bus.wr_data}, exp);
            end
            step();
            cnt[g] = cnt[g] + 4'h1;
            bus.req_data[g*8 +: 8] = {4'(g), cnt[g]};
        end
        bus.req_valid = 4'b0000;
    endtask

    task automatic test_full();
        logic [2:0]  fpat [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0]  d1;
        logic [15:0] exp;
        do_reset();
        d1 = 8'h40;
        bus.req_data[15:8]  = d1;
        bus.req_data[31:24] = 8'h60;
        bus.req_valid = 4'b1010;
        @(negedge clk);
        n_checks++;
        if (st !== 6'b0) begin
            n_fail++;
            $display("FAIL full_latency: got %b expected %b", st, 6'b0);
        end
        step();
        for (int c = 0; c < 7; c++) begin
            bus.wrt_full = fpat[c][0];
            @(negedge clk);
            if (fpat[c][0]) exp = {6'b10_0000, 2'd1, 8'h00};
            else            exp = {6'b11_0010, 2'd1, d1};
            n_checks++;
            if ({st, bus.grant_id, (fpat[c][0] ? 8'h00 : bus.wr_data)} !== exp) begin
                n_fail++;
                $display("FAIL full_cycle%0d: got %h expected %h", c, {st, bus.grant_id, bus.wr_data}, exp);
            end
            step();
            if (!fpat[c][0]) begin
                d1 = d1 + 8'h1;
                bus.req_data[15:8] = d1;
            end
        end
        bus.wrt_full = 1'b0;
        @(negedge clk);
        exp = {6'b11_1000, 2'd3, 8'h60};
        n_checks++;
        if ({st, bus.grant_id, bus.wr_data} !== exp) begin
            n_fail++;
            $display("FAIL full_rotate: got %h expected %h", {st, bus.grant_id, bus.wr_data}, exp);
        end
        bus.req_valid = 4'b0000;
    endtask

    task automatic test_drop();
        logic [15:0] exp;
        do_reset();
        bus.req_data[23:16] = 8'h80;
        bus.req_data[31:24] = 8'hA0;
        bus.req_valid = 4'b1100;
        step();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            exp = {6'b11_0100, 2'd2, 8'h80 + 8'(k)};
            n_checks++;
            if ({st, bus.grant_id, bus.wr_data} !== exp) begin
                n_fail++;
                $display("FAIL drop_beat%0d: got %h expected %h", k, {st, bus.grant_id, bus.wr_data}, exp);
            end
            step();
            bus.req_data[23:16] = 8'h81;
        end
        bus.req_valid = 4'b1000;
        @(negedge clk);
        n_checks++;
        if ({st, bus.grant_id} !== {6'b10_0100, 2'd2}) begin
            n_fail++;
            $display("FAIL drop_gap: got %b expected %b", {st, bus.grant_id}, {6'b10_0100, 2'd2});
        end
        step();
        @(negedge clk);
        exp = {6'b11_1000, 2'd3, 8'hA0};
        n_checks++;
        if ({st, bus.grant_id, bus.wr_data} !== exp) begin
            n_fail++;
            $display("FAIL drop_switch: got %h expected %h", {st, bus.grant_id, bus.wr_data}, exp);
        end
        bus.req_valid = 4'b0000;
    endtask

    task automatic test_async_reset();
        logic [15:0] exp;
        do_reset();
        bus.req_data[7:0] = 8'hC0;
        bus.req_valid = 4'b0001;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({st, bus.grant_id} !== 8'h00) begin
            n_fail++;
            $display("FAIL async_rst: got %b expected %b", {st, bus.grant_id}, 8'h00);
        end
        step();
        n_checks++;
        if (st !== 6'b0) begin
            n_fail++;
            $display("FAIL async_rst_hold: got %b expected %b", st, 6'b0);
        end
        bus.req_data[7:0]   = 8'hD0;
        bus.req_data[23:16] = 8'hE0;
        bus.req_valid = 4'b0101;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (st !== 6'b0) begin
            n_fail++;
            $display("FAIL async_idle: got %b expected %b", st, 6'b0);
        end
        step();
        @(negedge clk);
        exp = {6'b11_0001, 2'd0, 8'hD0};
        n_checks++;
        if ({st, bus.grant_id, bus.wr_data} !== exp) begin
            n_fail++;
            $display("FAIL async_prio: got %h expected %h", {st, bus.grant_id, bus.wr_data}, exp);
        end
        bus.req_valid = 4'b0000;
    endtask

    task automatic test_random();
        logic [5:0] seq  [4];
        int         pend [4];
        logic [3:0] xfer;
        logic [1:0] id;
        logic       over;
        do_reset();
        xfer = '0;
        for (int i = 0; i < 4; i++) begin
            seq[i]  = 6'd0;
            pend[i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (xfer[i]) seq[i] = seq[i] + 6'd1;
                if (!bus.req_valid[i] || xfer[i])
                    bus.req_valid[i] = ($urandom_range(0, 99) < 50);
                bus.req_data[i*8 +: 8] = {2'(i), seq[i]};
            end
            bus.wrt_full = ($urandom_range(0, 99) < 25);
            @(negedge clk);
            xfer = bus.req_valid & bus.req_ready;
            n_checks++;
            if (bus.wrt_ena && bus.wrt_full) begin
                n_fail++;
                $display("FAIL rand_full_write c%0d: got ena=1 full=1 expected ena=0", c);
            end
            n_checks++;
            if (!$onehot0(bus.req_ready) || ((xfer != 4'b0) !== bus.wrt_ena)) begin
                n_fail++;
                $display("FAIL rand_handshake c%0d: got ready=%b ena=%b expected one transfer per write",
                         c, bus.req_ready, bus.wrt_ena);
            end
            if (bus.wrt_ena) begin
                id = bus.wr_data[7:6];
                n_checks++;
                if (!xfer[id] || bus.wr_data[5:0] !== seq[id]) begin
                    n_fail++;
                    $display("FAIL rand_order c%0d: got %h expected %h", c, bus.wr_data, {id, seq[id]});
                end
            end
            over = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (xfer[i] || !bus.req_valid[i]) pend[i] = 0;
                else if (xfer != 4'b0)             pend[i] = pend[i] + 1;
                if (pend[i] > 12) over = 1'b1;
            end
            n_checks++;
            if (over) begin
                n_fail++;
                $display("FAIL rand_fairness c%0d: got wait %0d/%0d/%0d/%0d expected <= 12",
                         c, pend[0], pend[1], pend[2], pend[3]);
            end
            step();
        end
        bus.req_valid = 4'b0000;
        bus.wrt_full  = 1'b0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.wrt_full  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_drop();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
